// File: rtl/dmem_pkg.sv
// Shared types and lane/alignment helpers for the byte-addressed data memory.
package dmem_pkg;

   typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;
   typedef enum logic [1:0] {INIT, IDLE, WAIT, ACK} state_e;

   // Lane masks are built wide enough for any supported word and truncated by the user.
   localparam int LANES_MAX = 64;
   localparam int OFF_MAX_W = 6;

   function automatic size_e to_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic [LANES_MAX-1:0] byte_en(input size_e sz, input logic [OFF_MAX_W-1:0] off);
      case (sz)
         SZ_B:    return LANES_MAX'(1) << off;
         SZ_H:    return LANES_MAX'(3) << off;
         default: return '1;
      endcase
   endfunction

   function automatic logic is_misaligned(input size_e sz, input logic [OFF_MAX_W-1:0] off);
      case (sz)
         SZ_H:    return off[0];
         SZ_W:    return off != '0;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path alignment: moves the addressed byte/half down to bit 0 and extends it.
module dmem_load_align
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = 2
) (
   input  logic [DATA_W-1:0] raw,
   input  logic [OFF_W-1:0]  off,
   input  size_e             sz,
   input  logic              uns,
   output logic [DATA_W-1:0] data
);

   logic [15:0] sel;

   always_comb begin
      sel = 16'(raw >> {off, 3'b000});
      case (sz)
         SZ_B:    data = {{(DATA_W-8){~uns & sel[7]}}, sel[7:0]};
         SZ_H:    data = {{(DATA_W-16){~uns & sel[15]}}, sel[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with byte/half/word lanes, valid/ready handshake,
// configurable read latency and a one-word-per-cycle clear after reset.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 256,
   parameter int ADDR_W         = 32,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              SYS_reset,
   input  logic              DMEM_req_valid,
   output logic              DMEM_req_ready,
   input  logic              DMEM_mem_write,
   input  logic              DMEM_mem_read,
   input  logic [ADDR_W-1:0] DMEM_address,
   input  logic [1:0]        DMEM_size,
   input  logic              DMEM_unsigned,
   input  logic [DATA_W-1:0] DMEM_data_in,
   output logic              DMEM_rsp_valid,
   output logic [DATA_W-1:0] DMEM_data_out,
   output logic              DMEM_misaligned,
   output logic              DMEM_init_busy
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : IDLE;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [OFF_W-1:0]  off_q, off_d;
   size_e             sz_q, sz_d;
   logic              uns_q, uns_d;
   logic              load_q, load_d;
   logic              mis_q, mis_d;

   logic [IDX_W-1:0]  idx;
   logic [OFF_W-1:0]  off;
   size_e             sz;
   logic              is_st, is_ld, mis, acc, wr_en, clr_en;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] wdata, aligned;

   assign idx    = DMEM_address[OFF_W +: IDX_W];
   assign off    = DMEM_address[OFF_W-1:0];
   assign sz     = to_size(DMEM_size);
   assign is_st  = DMEM_mem_write;
   assign is_ld  = DMEM_mem_read & ~DMEM_mem_write;
   assign mis    = (is_st | is_ld) & is_misaligned(sz, OFF_MAX_W'(off));
   assign be     = NB'(byte_en(sz, OFF_MAX_W'(off)));
   assign wdata  = DMEM_data_in << {off, 3'b000};
   assign acc    = DMEM_req_valid & DMEM_req_ready;
   assign wr_en  = acc & is_st & ~mis;
   assign clr_en = (state_q == INIT);

   // Upper address bits only alias the array; they carry no information here.
   if (ADDR_W > OFF_W + IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^DMEM_address[ADDR_W-1:OFF_W+IDX_W];
   end

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[ptr_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_q <= RST_STATE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         off_q   <= '0;
         sz_q    <= SZ_W;
         uns_q   <= 1'b0;
         load_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         off_q   <= off_d;
         sz_q    <= sz_d;
         uns_q   <= uns_d;
         load_q  <= load_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      off_d   = off_q;
      sz_d    = sz_q;
      uns_d   = uns_q;
      load_d  = load_q;
      mis_d   = mis_q;
      case (state_q)
         INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH-1)) state_d = IDLE;
         end
         IDLE: begin
            if (acc) begin
               // Load data is captured now so a later store cannot disturb it.
               rdata_d = mem[idx];
               off_d   = off;
               sz_d    = sz;
               uns_d   = DMEM_unsigned;
               load_d  = is_ld & ~mis;
               mis_d   = mis;
               if (is_ld & ~mis) begin
                  state_d = WAIT;
                  cnt_d   = 2'(RD_LAT - 1);
               end else begin
                  state_d = ACK;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) state_d = ACK;
            else               cnt_d   = cnt_q - 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   dmem_load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
      .raw  (rdata_q),
      .off  (off_q),
      .sz   (sz_q),
      .uns  (uns_q),
      .data (aligned)
   );

   assign DMEM_req_ready  = (state_q == IDLE) & ~SYS_reset;
   assign DMEM_rsp_valid  = (state_q == ACK);
   assign DMEM_misaligned = (state_q == ACK) & mis_q;
   assign DMEM_data_out   = ((state_q == ACK) && load_q) ? aligned : '0;
   assign DMEM_init_busy  = (state_q == INIT);

endmodule
